int_ctrl: RTL and testbench

//  Interrupt controller driving the CPU CSR unit's int_taken/int_id inputs. Collects peripheral

---
 rtl/int_ctrl_pkg.sv | 18 +
 rtl/int_ctrl_if.sv | 33 +++
 rtl/int_prio_enc.sv | 23 ++
 rtl/int_ctrl.sv | 119 +++++++++++
 tb/tb_int_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: source IDs and FSM states.
package int_ctrl_pkg;

  localparam int NUM_SRC     = 3;
  localparam int INT_ID_BITS = 2;

  localparam logic [INT_ID_BITS-1:0] INT_NONE  = 2'd0;
  localparam logic [INT_ID_BITS-1:0] INT_SCTRL = 2'd1;
  localparam logic [INT_ID_BITS-1:0] INT_DMA   = 2'd2;
  localparam logic [INT_ID_BITS-1:0] INT_EPU   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    SERVE = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Bundle between peripherals/CPU (master) and the interrupt controller (slave).
//
// Handshake: int_taken_o is a level request, held with a stable int_id_o until the CPU
// returns int_ack_i for one cycle; the controller then keeps int_id_o while busy_o is
// high and releases it on a one-cycle mret_i. Neither ack nor mret is ever retracted.
interface int_ctrl_if
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC   = NUM_SRC,
  parameter int ID_BITS = INT_ID_BITS
);

  logic [N_SRC-1:0]   irq_src_i;
  logic [N_SRC-1:0]   irq_en_i;
  logic               int_ack_i;
  logic               mret_i;
  logic               int_taken_o;
  logic [ID_BITS-1:0] int_id_o;
  logic [N_SRC-1:0]   pend_o;
  logic               busy_o;
  int_state_e         state_o;

  modport slave (
    input  irq_src_i, irq_en_i, int_ack_i, mret_i,
    output int_taken_o, int_id_o, pend_o, busy_o, state_o
  );

  modport master (
    output irq_src_i, irq_en_i, int_ack_i, mret_i,
    input  int_taken_o, int_id_o, pend_o, busy_o, state_o
  );

endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, bit i reports ID i+1, ID 0 when none.
module int_prio_enc #(
  parameter int NUM_SRC     = 3,
  parameter int INT_ID_BITS = 2
) (
  input  logic [NUM_SRC-1:0]     req_i,
  output logic [INT_ID_BITS-1:0] id_o,
  output logic                   valid_o
);

  // Scan from the top down so the lowest index is the last (winning) assignment.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = INT_ID_BITS'(i + 1);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending capture, masking, fixed-priority pick and CPU ack/mret FSM.
// Define INT_CTRL_EDGE_EN for edge-triggered pending bits; default is level-sensitive.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = int_ctrl_pkg::NUM_SRC,
  parameter int INT_ID_BITS = int_ctrl_pkg::INT_ID_BITS
) (
  input  logic      clk,
  input  logic      rst,
  int_ctrl_if.slave bus
);

  int_state_e               state_q;
  logic                     taken_q;
  logic [INT_ID_BITS-1:0]   id_q;
  logic                     busy_q;
  logic [NUM_SRC-1:0]       pend_q;
  logic [NUM_SRC-1:0]       pend_d;
  logic [NUM_SRC-1:0]       en_q;
  logic [NUM_SRC-1:0]       eligible;
  logic [INT_ID_BITS-1:0]   win_id;
  logic                     win_valid;
  logic                     ack_take;

  // The mask is sampled alongside the requests, so unmasking and raising a request
  // both reach int_taken_o through the same two registers.
  assign eligible = pend_q & en_q;
  assign ack_take = (state_q == PEND) && bus.int_ack_i;

  int_prio_enc #(
    .NUM_SRC     (NUM_SRC),
    .INT_ID_BITS (INT_ID_BITS)
  ) u_prio_enc (
    .req_i   (eligible),
    .id_o    (win_id),
    .valid_o (win_valid)
  );

`ifdef INT_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;

  // src_q resets to 0 so a request still high after reset counts as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
    end else begin
      src_q <= bus.irq_src_i;
    end
  end

  // Only the served source is cleared on ack; a coincident new edge wins over the clear.
  always_comb begin
    clr  = '0;
    rise = bus.irq_src_i & ~src_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_take && (id_q == INT_ID_BITS'(i + 1))) begin
        clr[i] = 1'b1;
      end
    end
    pend_d = (pend_q & ~clr) | rise;
  end
`else
  assign pend_d = bus.irq_src_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      id_q    <= INT_NONE;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      en_q    <= '0;
    end else begin
      pend_q <= pend_d;
      en_q   <= bus.irq_en_i;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q <= PEND;
            taken_q <= 1'b1;
            id_q    <= win_id;
          end
        end
        PEND: begin
          // The latched ID is never retracted or preempted; mret is meaningless here.
          if (bus.int_ack_i) begin
            state_q <= SERVE;
            taken_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SERVE: begin
          if (bus.mret_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            id_q    <= INT_NONE;
          end
        end
        default: begin
          state_q <= IDLE;
          taken_q <= 1'b0;
          busy_q  <= 1'b0;
          id_q    <= INT_NONE;
        end
      endcase
    end
  end

  assign bus.int_taken_o = taken_q;
  assign bus.int_id_o    = id_q;
  assign bus.pend_o      = pend_q;
  assign bus.busy_o      = busy_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: stimulus pushes per-cycle expectations, a monitor pops and checks.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

`ifdef INT_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passes;

  // Expected {int_taken, int_id[1:0], pend[2:0], busy}, tagged with the cycle it applies to.
  logic [6:0] exp_q[$];
  int         exp_cyc_q[$];
  string      exp_name_q[$];

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish within 200000 time units");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.irq_src_i = 3'b000;
    bus.irq_en_i  = 3'b000;
    bus.int_ack_i = 1'b0;
    bus.mret_i    = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic t, input logic [1:0] id,
                            input logic [2:0] p, input logic b);
    exp_q.push_back({t, id, p, b});
    exp_cyc_q.push_back(cyc);
    exp_name_q.push_back(nm);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] act;
    int         ec;
    string      nm;
    while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      e   = exp_q.pop_front();
      ec  = exp_cyc_q.pop_front();
      nm  = exp_name_q.pop_front();
      act = {bus.int_taken_o, bus.int_id_o, bus.pend_o, bus.busy_o};
      checks = checks + 1;
      if (ec != cyc) begin
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", nm, ec, cyc);
      end else if (act !== e) begin
        $display("FAIL %s: got taken=%b id=%0d pend=%b busy=%b, expected taken=%b id=%0d pend=%b busy=%b",
                 nm, act[6], act[5:4], act[3:1], act[0], e[6], e[5:4], e[3:1], e[0]);
      end else begin
        passes = passes + 1;
      end
    end
  end

  initial begin
    cyc    = 0;
    checks = 0;
    passes = 0;

    // 1: reset with all sources requesting and enabled
    rst           = 1'b1;
    bus.irq_src_i = 3'b111;
    bus.irq_en_i  = 3'b111;
    bus.int_ack_i = 1'b0;
    bus.mret_i    = 1'b0;
    tick(); expect_out("rst_hold0", 0, 0, 3'b000, 0);
    tick(); expect_out("rst_hold1", 0, 0, 3'b000, 0);
    rst = 1'b0;
    tick(); expect_out("rst_capture", 0, 0, 3'b111, 0);
    tick(); expect_out("rst_present", 1, 1, 3'b111, 0);
    bus.int_ack_i = 1'b1; bus.irq_src_i = 3'b000;
    tick(); expect_out("rst_ack", 0, 1, EDGE ? 3'b110 : 3'b000, 1);

    // 2: DMA and EPU together, served in priority order
    do_reset();
    bus.irq_src_i = 3'b110; bus.irq_en_i = 3'b111;
    tick(); expect_out("pri_capture", 0, 0, 3'b110, 0);
    tick(); expect_out("pri_dma", 1, 2, 3'b110, 0);
    bus.int_ack_i = 1'b1; bus.irq_src_i = 3'b100;
    tick(); expect_out("pri_dma_ack", 0, 2, 3'b100, 1);
    bus.int_ack_i = 1'b0; bus.mret_i = 1'b1;
    tick(); expect_out("pri_mret", 0, 0, 3'b100, 0);
    bus.mret_i = 1'b0;
    tick(); expect_out("pri_epu", 1, 3, 3'b100, 0);
    bus.int_ack_i = 1'b1; bus.irq_src_i = 3'b000;
    tick(); expect_out("pri_epu_ack", 0, 3, 3'b000, 1);

    // 3: masked EPU stays pending; ack in IDLE is ignored; unmask presents it
    do_reset();
    bus.irq_src_i = 3'b100; bus.irq_en_i = 3'b011; bus.int_ack_i = 1'b1;
    tick(); expect_out("mask_pend", 0, 0, 3'b100, 0);
    bus.int_ack_i = 1'b0;
    tick(); expect_out("mask_hold", 0, 0, 3'b100, 0);
    bus.irq_en_i = 3'b111;
    tick(); expect_out("unmask_wait", 0, 0, 3'b100, 0);
    tick(); expect_out("unmask_present", 1, 3, 3'b100, 0);
    bus.int_ack_i = 1'b1; bus.irq_src_i = 3'b000;
    tick(); expect_out("unmask_ack", 0, 3, 3'b000, 1);

    // 4: mret in PEND ignored, source drop does not retract
    do_reset();
    bus.irq_src_i = 3'b001; bus.irq_en_i = 3'b111;
    tick(); expect_out("hold_capture", 0, 0, 3'b001, 0);
    tick(); expect_out("hold_present", 1, 1, 3'b001, 0);
    bus.mret_i = 1'b1;
    tick(); expect_out("hold_mret", 1, 1, 3'b001, 0);
    bus.mret_i = 1'b0; bus.irq_src_i = 3'b000;
    tick(); expect_out("hold_drop0", 1, 1, EDGE ? 3'b001 : 3'b000, 0);
    tick(); expect_out("hold_drop1", 1, 1, EDGE ? 3'b001 : 3'b000, 0);
    bus.int_ack_i = 1'b1;
    tick(); expect_out("hold_ack", 0, 1, 3'b000, 1);
    bus.int_ack_i = 1'b0;

    // 5: DMA pulse during SERVE of SCTRL
    do_reset();
    bus.irq_src_i = 3'b001; bus.irq_en_i = 3'b111;
    tick(); expect_out("pulse_capture", 0, 0, 3'b001, 0);
    tick(); expect_out("pulse_present", 1, 1, 3'b001, 0);
    bus.int_ack_i = 1'b1; bus.irq_src_i = 3'b000;
    tick(); expect_out("pulse_serve", 0, 1, 3'b000, 1);
    bus.int_ack_i = 1'b0; bus.irq_src_i = 3'b010;
    tick(); expect_out("pulse_high", 0, 1, 3'b010, 1);
    bus.irq_src_i = 3'b000;
    tick(); expect_out("pulse_low", 0, 1, EDGE ? 3'b010 : 3'b000, 1);
    bus.mret_i = 1'b1;
    tick(); expect_out("pulse_mret", 0, 0, EDGE ? 3'b010 : 3'b000, 0);
    bus.mret_i = 1'b0;
    tick(); expect_out("pulse_after", EDGE, EDGE ? 2'd2 : 2'd0, EDGE ? 3'b010 : 3'b000, 0);

    // 6: reset in SERVE, level request recaptured afterwards
    do_reset();
    bus.irq_src_i = 3'b001; bus.irq_en_i = 3'b111;
    tick(); expect_out("rs_capture", 0, 0, 3'b001, 0);
    tick(); expect_out("rs_present", 1, 1, 3'b001, 0);
    bus.int_ack_i = 1'b1;
    tick(); expect_out("rs_serve", 0, 1, EDGE ? 3'b000 : 3'b001, 1);
    bus.int_ack_i = 1'b0; rst = 1'b1;
    tick(); expect_out("rs_reset", 0, 0, 3'b000, 0);
    rst = 1'b0;
    tick(); expect_out("rs_recapture", 0, 0, 3'b001, 0);
    tick(); expect_out("rs_represent", 1, 1, 3'b001, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      checks = checks + 1;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
